// File: rtl/adc_touch_pkg.sv
// Shared types and frame constants for the touch-panel ADC SPI transfer engine.
package adc_touch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_X    = 2'd1,
    ST_Y    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int FRAME_LEN  = 24;
  localparam int CMD_BITS   = 8;
  localparam int DATA_FIRST = 9;
  localparam int DATA_LAST  = 20;
  localparam int RES_W      = 12;
  localparam int K_W        = 5;

  localparam int                  CLK_DIV_DEF = 25;
  localparam logic [CMD_BITS-1:0] CMD_X_DEF   = 8'h90;
  localparam logic [CMD_BITS-1:0] CMD_Y_DEF   = 8'hD0;

  // Mean of two conversions; the carry is kept so the halving never wraps.
  function automatic logic [RES_W-1:0] avg2(input logic [RES_W-1:0] a,
                                            input logic [RES_W-1:0] b);
    logic [RES_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[RES_W:1];
  endfunction

endpackage

// File: rtl/adc_dclk_gen.sv
// DCLK generator: prescaler, DCLK register and rise/fall strobes for the transfer engine.
module adc_dclk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic en,
  input  logic clr,
  output logic dclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dclk_q, dclk_d;
  logic          tick;

  // Strobes mark the cycle whose closing edge moves DCLK.
  assign tick = en && (cnt_q == CNT_MAX);
  assign rise = tick && !dclk_q;
  assign fall = tick && dclk_q;
  assign dclk = dclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    dclk_d = dclk_q;
    if (clr || !en) begin
      cnt_d  = '0;
      dclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      dclk_d = !dclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q  <= '0;
      dclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dclk_q <= dclk_d;
    end
  end

endmodule

// File: rtl/adc_spi_transfer.sv
// Touch-panel ADC SPI transfer engine: X then Y frames, per-axis done flags, commit on FIN_TRANS.
// Defining ADC_AVG_EN converts each axis twice and holds the truncated mean.
module adc_spi_transfer
  import adc_touch_pkg::*;
#(
  parameter int                  CLK_DIV = CLK_DIV_DEF,
  parameter logic [CMD_BITS-1:0] CMD_X   = CMD_X_DEF,
  parameter logic [CMD_BITS-1:0] CMD_Y   = CMD_Y_DEF
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              ENA_TRANS,
  input  logic              FIN_TRANS,
  input  logic              ADC_DOUT,
  output logic              ADC_DCLK,
  output logic              ADC_DIN,
  output logic              ENABLE_1,
  output logic              ENABLE_2,
  output logic [RES_W-1:0]  X_COORD,
  output logic [RES_W-1:0]  Y_COORD,
  output logic              DATA_VALID
);

  localparam logic [K_W-1:0] K_LAST  = K_W'(FRAME_LEN - 1);
  localparam logic [K_W-1:0] K_FIRST = K_W'(DATA_FIRST);
  localparam logic [K_W-1:0] K_DLAST = K_W'(DATA_LAST);

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic [RES_W-1:0]    x_hold_q, x_hold_d, y_hold_q, y_hold_d;
  logic [RES_W-1:0]    x_coord_q, x_coord_d, y_coord_q, y_coord_d;
  logic                en1_q, en1_d, en2_q, en2_d, dv_q, dv_d;
  logic                last_conv;
  logic [RES_W-1:0]    axis_res;
`ifdef ADC_AVG_EN
  logic                conv_q, conv_d;
  logic [RES_W-1:0]    r0_q, r0_d;
`endif

  logic active, clr, rise, fall;

  assign active = (state_q == ST_X) || (state_q == ST_Y);
  assign clr    = active && (state_d != ST_X) && (state_d != ST_Y);

  adc_dclk_gen #(.CLK_DIV(CLK_DIV)) u_dclk (
    .CLK  (CLK),
    .RST_n(RST_n),
    .en   (active),
    .clr  (clr),
    .dclk (ADC_DCLK),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cmd_d     = cmd_q;
    res_d     = res_q;
    x_hold_d  = x_hold_q;
    y_hold_d  = y_hold_q;
    x_coord_d = x_coord_q;
    y_coord_d = y_coord_q;
    en1_d     = en1_q;
    en2_d     = en2_q;
    dv_d      = 1'b0;
`ifdef ADC_AVG_EN
    conv_d    = conv_q;
    r0_d      = r0_q;
    last_conv = conv_q;
    axis_res  = avg2(r0_q, res_q);
`else
    last_conv = 1'b1;
    axis_res  = res_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ENA_TRANS) begin
          state_d = ST_X;
          k_d     = '0;
          cmd_d   = CMD_X;
`ifdef ADC_AVG_EN
          conv_d  = 1'b0;
`endif
        end
      end
      ST_X, ST_Y: begin
        if (!ENA_TRANS && !FIN_TRANS) begin
          state_d = ST_IDLE;
          k_d     = '0;
          cmd_d   = '0;
          en1_d   = 1'b0;
          en2_d   = 1'b0;
        end else begin
          if (rise && (k_q >= K_FIRST) && (k_q <= K_DLAST))
            res_d = {res_q[RES_W-2:0], ADC_DOUT};
          if (fall) begin
            if (k_q == K_LAST) begin
              k_d = '0;
`ifdef ADC_AVG_EN
              conv_d = !conv_q;
              r0_d   = res_q;
`endif
              if (!last_conv) begin
                cmd_d = (state_q == ST_X) ? CMD_X : CMD_Y;
              end else if (state_q == ST_X) begin
                x_hold_d = axis_res;
                en1_d    = 1'b1;
                state_d  = ST_Y;
                cmd_d    = CMD_Y;
              end else begin
                y_hold_d = axis_res;
                en2_d    = 1'b1;
                state_d  = ST_DONE;
                cmd_d    = '0;
              end
            end else begin
              k_d   = k_q + 1'b1;
              cmd_d = {cmd_q[CMD_BITS-2:0], 1'b0};
            end
          end
        end
      end
      ST_DONE: begin
        // FIN_TRANS wins over a simultaneous ENA_TRANS drop.
        if (FIN_TRANS) begin
          x_coord_d = x_hold_q;
          y_coord_d = y_hold_q;
          dv_d      = 1'b1;
          en1_d     = 1'b0;
          en2_d     = 1'b0;
          state_d   = ST_IDLE;
        end else if (!ENA_TRANS) begin
          en1_d   = 1'b0;
          en2_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      cmd_q     <= '0;
      res_q     <= '0;
      x_hold_q  <= '0;
      y_hold_q  <= '0;
      x_coord_q <= '0;
      y_coord_q <= '0;
      en1_q     <= 1'b0;
      en2_q     <= 1'b0;
      dv_q      <= 1'b0;
`ifdef ADC_AVG_EN
      conv_q    <= 1'b0;
      r0_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cmd_q     <= cmd_d;
      res_q     <= res_d;
      x_hold_q  <= x_hold_d;
      y_hold_q  <= y_hold_d;
      x_coord_q <= x_coord_d;
      y_coord_q <= y_coord_d;
      en1_q     <= en1_d;
      en2_q     <= en2_d;
      dv_q      <= dv_d;
`ifdef ADC_AVG_EN
      conv_q    <= conv_d;
      r0_q      <= r0_d;
`endif
    end
  end

  assign ADC_DIN    = cmd_q[CMD_BITS-1];
  assign ENABLE_1   = en1_q;
  assign ENABLE_2   = en2_q;
  assign X_COORD    = x_coord_q;
  assign Y_COORD    = y_coord_q;
  assign DATA_VALID = dv_q;

endmodule

// File: tb/tb_adc_spi_transfer.sv
// Scoreboard bench for adc_spi_transfer at CLK_DIV=4 with a DCLK-driven ADC model.
module tb_adc_spi_transfer;

  localparam int CLK_DIV = 4;
`ifdef ADC_AVG_EN
  localparam int NF = 4, LAT1 = 385, LAT2 = 769, NCOMMIT = 5;
`else
  localparam int NF = 2, LAT1 = 193, LAT2 = 385, NCOMMIT = 4;
`endif

  logic        CLK, RST_n, ENA_TRANS, FIN_TRANS, ADC_DOUT;
  logic        ADC_DCLK, ADC_DIN, ENABLE_1, ENABLE_2, DATA_VALID;
  logic [11:0] X_COORD, Y_COORD;

  adc_spi_transfer #(.CLK_DIV(CLK_DIV)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .ENA_TRANS (ENA_TRANS),
    .FIN_TRANS (FIN_TRANS),
    .ADC_DOUT  (ADC_DOUT),
    .ADC_DCLK  (ADC_DCLK),
    .ADC_DIN   (ADC_DIN),
    .ENABLE_1  (ENABLE_1),
    .ENABLE_2  (ENABLE_2),
    .X_COORD   (X_COORD),
    .Y_COORD   (Y_COORD),
    .DATA_VALID(DATA_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  exp_t        exp_q[$];
  int          checks, errors, dv_count, n_neg;
  logic [11:0] mres[4];
  logic [7:0]  din_byte[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // ADC model: each DCLK fall opens a new period; n_neg is the global period index.
  always @(negedge ADC_DCLK) begin
    int k, f, idx;
    n_neg++;
    k = n_neg % 24;
    f = n_neg / 24;
`ifdef ADC_AVG_EN
    idx = f;
`else
    idx = f * 2;
`endif
    if (k >= 9 && k <= 20 && idx < 4) ADC_DOUT = mres[idx][20-k];
    else ADC_DOUT = 1'b0;
  end

  always @(posedge ADC_DCLK) begin
    int k, f;
    k = n_neg % 24;
    f = n_neg / 24;
    if (k < 8 && f < 4) din_byte[f] = {din_byte[f][6:0], ADC_DIN};
  end

  // Monitor: every DATA_VALID pulse must match the oldest expected commit.
  always begin
    @(posedge CLK);
    #1;
    if (RST_n === 1'b1 && DATA_VALID === 1'b1) begin
      dv_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_valid: got pulse x=0x%0h y=0x%0h, expected none",
                 X_COORD, Y_COORD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("x_coord", X_COORD, e.x);
        check("y_coord", Y_COORD, e.y);
      end
    end
  end

  task automatic set_model(input logic [11:0] x0, x1, y0, y1);
    mres[0] = x0;
    mres[1] = x1;
    mres[2] = y0;
    mres[3] = y1;
  endtask

  task automatic start_frame();
    @(posedge CLK);
    #1;
    n_neg = 0;
    for (int i = 0; i < 4; i++) din_byte[i] = 8'h00;
    ENA_TRANS = 1'b1;
  endtask

  task automatic run_axes(input int fin_at, output int c1, output int c2);
    start_frame();
    c1 = 0;
    c2 = 0;
    for (int i = 1; i <= 2000 && c2 == 0; i++) begin
      @(posedge CLK);
      #1;
      FIN_TRANS = (i == fin_at);
      if (ENABLE_1 === 1'b1 && c1 == 0) c1 = i;
      if (ENABLE_2 === 1'b1 && c2 == 0) c2 = i;
    end
    FIN_TRANS = 1'b0;
    check("enable_1_latency", c1, LAT1);
    check("enable_2_latency", c2, LAT2);
    check("enable_1_held_at_enable_2", ENABLE_1, 1);
  endtask

  task automatic commit(input bit drop_ena);
    FIN_TRANS = 1'b1;
    if (drop_ena) ENA_TRANS = 1'b0;
    @(posedge CLK);
    #1;
    FIN_TRANS = 1'b0;
    ENA_TRANS = 1'b0;
    check("commit_data_valid", DATA_VALID, 1);
    check("commit_enable_1_clr", ENABLE_1, 0);
    check("commit_enable_2_clr", ENABLE_2, 0);
    @(posedge CLK);
    #1;
    check("data_valid_one_cycle", DATA_VALID, 0);
  endtask

  initial begin
    int c1, c2;
    RST_n = 1'b0;
    ENA_TRANS = 1'b0;
    FIN_TRANS = 1'b0;
    ADC_DOUT = 1'b0;
    checks = 0;
    errors = 0;
    dv_count = 0;
    n_neg = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dclk", ADC_DCLK, 0);
    check("rst_din", ADC_DIN, 0);
    check("rst_enable_1", ENABLE_1, 0);
    check("rst_enable_2", ENABLE_2, 0);
    check("rst_x_coord", X_COORD, 0);
    check("rst_y_coord", Y_COORD, 0);
    check("rst_data_valid", DATA_VALID, 0);
    RST_n = 1'b1;

    // 1: full transfer, commit with ENA_TRANS still high.
    set_model(12'hA5C, 12'hA5C, 12'h3F1, 12'h3F1);
    exp_q.push_back('{x: 12'hA5C, y: 12'h3F1});
    run_axes(0, c1, c2);
    for (int f = 0; f < NF; f++)
      check($sformatf("din_cmd_frame%0d", f), din_byte[f], (f < NF / 2) ? 8'h90 : 8'hD0);
    repeat (5) @(posedge CLK);
    #1;
    check("done_dclk_low", ADC_DCLK, 0);
    check("done_enable_2_held", ENABLE_2, 1);
    commit(1'b0);
    check("t1_x_after", X_COORD, 12'hA5C);

    // 2: FIN_TRANS coincident with ENA_TRANS fall.
    exp_q.push_back('{x: 12'hA5C, y: 12'h3F1});
    run_axes(0, c1, c2);
    commit(1'b1);

    // 3: abort at k=12 of the Y frame.
    set_model(12'h123, 12'h123, 12'h456, 12'h456);
    start_frame();
    for (int i = 0; i < 2000 && n_neg < 36; i++) begin
      @(posedge CLK);
      #1;
    end
    check("abort_reached_y_k12", (n_neg >= 36), 1);
    @(posedge CLK);
    #1;
    ENA_TRANS = 1'b0;
    @(posedge CLK);
    #1;
    check("abort_dclk", ADC_DCLK, 0);
    check("abort_din", ADC_DIN, 0);
    check("abort_enable_1", ENABLE_1, 0);
    check("abort_x_kept", X_COORD, 12'hA5C);
    check("abort_y_kept", Y_COORD, 12'h3F1);
    repeat (10) @(posedge CLK);
    #1;
    check("abort_stays_idle_dclk", ADC_DCLK, 0);

    // 4: asynchronous reset at k=5 of X, then clean restart.
    set_model(12'h7E2, 12'h7E2, 12'h05A, 12'h05A);
    start_frame();
    for (int i = 0; i < 2000 && n_neg < 5; i++) begin
      @(posedge CLK);
      #1;
    end
    @(posedge CLK);
    #3;
    RST_n = 1'b0;
    #1;
    check("arst_dclk", ADC_DCLK, 0);
    check("arst_din", ADC_DIN, 0);
    check("arst_x_coord", X_COORD, 0);
    check("arst_y_coord", Y_COORD, 0);
    check("arst_enable_1", ENABLE_1, 0);
    ENA_TRANS = 1'b0;
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    exp_q.push_back('{x: 12'h7E2, y: 12'h05A});
    run_axes(0, c1, c2);
    commit(1'b1);

    // 5: FIN_TRANS during the X frame is ignored.
    set_model(12'h9C3, 12'h9C3, 12'h21E, 12'h21E);
    exp_q.push_back('{x: 12'h9C3, y: 12'h21E});
    run_axes(50, c1, c2);
    commit(1'b1);

`ifdef ADC_AVG_EN
    // 6: two conversions per axis averaged.
    set_model(12'h100, 12'h103, 12'h200, 12'h205);
    exp_q.push_back('{x: 12'h101, y: 12'h202});
    run_axes(0, c1, c2);
    commit(1'b1);
`endif

    repeat (5) @(posedge CLK);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("data_valid_count", dv_count, NCOMMIT);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
